// File: rtl/xor_64b_if.sv
// Operand/result bundle for xor_64b: an operand pair goes in and a registered XOR result
// comes out with zero and parity flags.
// Handshake: a and b are accepted on every rising edge where in_valid=1. There is no ready
// signal and no backpressure. out_valid=1 marks the single cycle in which s, zero and parity
// hold the result of the pair accepted on the previous edge.
interface xor_64b_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             out_valid;
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, a, b,
    input  s, out_valid, zero, parity
  );

  modport slave (
    input  in_valid, a, b,
    output s, out_valid, zero, parity
  );
endinterface

// File: rtl/xor_64b.sv
// Registered bitwise XOR of two WIDTH-bit operands with zero and parity flags.
// The result has a latency of one clock. While no new pair arrives, the result registers hold their values.
module xor_64b #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      reset,
  xor_64b_if.slave  bus
);

  logic [WIDTH-1:0] s_d, s_q;
  logic             zero_d, zero_q;
  logic             parity_d, parity_q;
  logic             out_valid_d, out_valid_q;

  // zero and parity are taken from s_d, the same value that is loaded into s_q.
  // This keeps the three outputs coherent.
  always_comb begin
    s_d         = s_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      s_d         = bus.a ^ bus.b;
      zero_d      = (s_d == '0);
      parity_d    = ^s_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_xor_64b.sv
// Self-checking bench for xor_64b: a cycle-level reference model plus directed vectors.
// The bench also runs an exhaustive sweep of the low byte.
module tb_xor_64b;
  localparam int W = 64;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  xor_64b_if #(.WIDTH(W)) bus ();

  xor_64b #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: expected output state after each edge, plus a queue of pending results
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_s;
  logic         m_zero, m_par, m_ov, m_ok;

  initial m_ok = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] r;
    int           ones;
    if (reset) begin
      exp_q.delete();
      m_s    <= '0;
      m_zero <= 1'b1;
      m_par  <= 1'b0;
      m_ov   <= 1'b0;
      m_ok   <= 1'b1;
    end else if (bus.in_valid) begin
      r = '0;
      ones = 0;
      for (int i = 0; i < W; i++) begin
        r[i] = (bus.a[i] != bus.b[i]);
        ones = ones + int'(r[i]);
      end
      exp_q.push_back(r);
      m_s    <= r;
      m_zero <= (ones == 0);
      m_par  <= ((ones % 2) == 1);
      m_ov   <= 1'b1;
    end else begin
      m_ov <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // compare process: every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("cyc_out_valid", W'(bus.out_valid), W'(m_ov));
      chk("cyc_s",         bus.s,             m_s);
      chk("cyc_zero",      W'(bus.zero),      W'(m_zero));
      chk("cyc_parity",    W'(bus.parity),    W'(m_par));
      if (m_ov) begin
        if (exp_q.size() == 0) chk("cyc_queue_empty", W'(1), W'(0));
        else chk("cyc_s_vs_queue", bus.s, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = aa;
    bus.b        = bb;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input logic [W-1:0] s, input logic z,
                     input logic p, input logic ov);
    chk({tag, "_s"},         bus.s,             s);
    chk({tag, "_zero"},      W'(bus.zero),      W'(z));
    chk({tag, "_parity"},    W'(bus.parity),    W'(p));
    chk({tag, "_out_valid"}, W'(bus.out_valid), W'(ov));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) settle();
    lit("reset_state", 64'h0, 1'b1, 1'b0, 1'b0);

    @(negedge clk) reset = 1'b0;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    settle();
    lit("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    settle();
    lit("a_eq_b", 64'h0, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5554);
    settle();
    lit("odd_ones", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1);

    drive(1'b1, 64'h3C, 64'hA5);
    settle();
    lit("byte_3c_a5", 64'h99, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 64'h1234, 64'h0);
    settle();
    lit("idle_hold", 64'h99, 1'b0, 1'b0, 1'b0);

    // three back-to-back pairs, then idle
    drive(1'b1, 64'h0000_0000_0000_0F0F, 64'h0000_0000_0000_00FF);
    settle();
    lit("b2b_1", 64'h0000_0000_0000_0FF0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h0);
    settle();
    lit("b2b_2", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    settle();
    lit("b2b_3", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'h0, 64'h0);
    settle();
    lit("b2b_idle", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // reset together with a valid pair discards the pair
    drive(1'b1, 64'h1, 64'h0);
    reset = 1'b1;
    settle();
    lit("reset_discard", 64'h0, 1'b1, 1'b0, 1'b0);

    // result pending when reset arrives mid-stream, then recovery
    @(negedge clk) reset = 1'b0;
    drive(1'b1, 64'h7, 64'h0);
    @(negedge clk) reset = 1'b1;
    bus.a = 64'hF0;
    settle();
    lit("mid_reset", 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    bus.a = 64'h7;
    bus.b = 64'h0;
    settle();
    lit("after_reset", 64'h7, 1'b0, 1'b1, 1'b1);

    // exhaustive low byte, one pair per cycle
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        drive(1'b1, W'(i), W'(j));
      end
    end
    drive(1'b0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
